vscale_htif_pcr_arbiter: RTL and testbench

- Shares the single HTIF PCR request/response port of the CSR file between two host-side requesters, for example the test-harness HTIF and a debug transport.
- Allows one transaction in flight at a time, with round-robin grant and registered request capture.
- Routes each response back to the requester that issued the request.
- Sits between the host interfaces and vscale_csr_file's htif_pcr_* port. Adds a response timeout, so a hung CSR-side handshake cannot lock out both hosts.

---
 rtl/vscale_htif_pcr_arbiter_pkg.sv | 14 +
 rtl/vscale_htif_pcr_arbiter_rr_arb2.sv | 19 +
 rtl/vscale_htif_pcr_arbiter.sv | 150 +++++++++++++++
 tb/tb_vscale_htif_pcr_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vscale_htif_pcr_arbiter_pkg.sv
// Shared encodings for the HTIF PCR arbiter: FSM states, requester count and timer width.
package vscale_htif_pcr_arbiter_pkg;

    localparam int HTIF_ARB_NREQ = 2;
    localparam int HTIF_ARB_TIMER_W = 16;

    typedef enum logic [1:0] {
        HTIF_ARB_IDLE  = 2'd0,
        HTIF_ARB_ISSUE = 2'd1,
        HTIF_ARB_WAIT  = 2'd2,
        HTIF_ARB_RESP  = 2'd3
    } htif_arb_state_e;

endpackage

// File: rtl/vscale_htif_pcr_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: on contention the requester that
// did not go last (rr_ptr) wins.
module vscale_rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       rr_ptr,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |req_valid;
        if (&req_valid) begin
            grant_idx = ~rr_ptr;
        end else begin
            grant_idx = req_valid[1];
        end
    end

endmodule

// File: rtl/vscale_htif_pcr_arbiter.sv
// Shares the CSR file's single HTIF PCR port between two hosts, one transaction
// at a time, with round-robin grant, response routing and a response timeout.
module vscale_htif_pcr_arbiter
    import vscale_htif_pcr_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_rw,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_data,
    output logic [1:0]            resp_valid,
    input  logic [1:0]            resp_ready,
    output logic [DATA_W-1:0]     resp_data,
    output logic                  resp_err,
    output logic                  htif_pcr_req_valid,
    input  logic                  htif_pcr_req_ready,
    output logic                  htif_pcr_req_rw,
    output logic [ADDR_W-1:0]     htif_pcr_req_addr,
    output logic [DATA_W-1:0]     htif_pcr_req_data,
    input  logic                  htif_pcr_resp_valid,
    output logic                  htif_pcr_resp_ready,
    input  logic [DATA_W-1:0]     htif_pcr_resp_data,
    output logic                  timeout_sticky
);

    localparam logic [HTIF_ARB_TIMER_W-1:0] TIMEOUT_LAST = HTIF_ARB_TIMER_W'(TIMEOUT_CYCLES - 1);

    htif_arb_state_e             state, state_next;
    logic                        rr_ptr;
    logic                        owner;
    logic [HTIF_ARB_TIMER_W-1:0] timer;
    logic                        cap_rw;
    logic [ADDR_W-1:0]           cap_addr;
    logic [DATA_W-1:0]           cap_data;

    logic grant_valid, grant_idx;
    logic accept, issue_done, resp_hit, expire, retire;

    vscale_rr_arb2 u_rr_arb2 (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HTIF_ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        accept              = 1'b0;
        issue_done          = 1'b0;
        resp_hit            = 1'b0;
        expire              = 1'b0;
        retire              = 1'b0;
        req_ready           = 2'b00;
        resp_valid          = 2'b00;
        htif_pcr_req_valid  = 1'b0;
        htif_pcr_resp_ready = 1'b0;
        case (state)
            HTIF_ARB_IDLE: begin
                // Gated by reset_n so no requester sees an accept while reset is held.
                if (grant_valid && reset_n) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_next           = HTIF_ARB_ISSUE;
                end
            end
            HTIF_ARB_ISSUE: begin
                htif_pcr_req_valid = 1'b1;
                if (htif_pcr_req_ready) begin
                    issue_done = 1'b1;
                    state_next = HTIF_ARB_WAIT;
                end
            end
            HTIF_ARB_WAIT: begin
                htif_pcr_resp_ready = 1'b1;
                if (htif_pcr_resp_valid) begin
                    resp_hit   = 1'b1;
                    state_next = HTIF_ARB_RESP;
                end else if (timer == TIMEOUT_LAST) begin
                    expire     = 1'b1;
                    state_next = HTIF_ARB_RESP;
                end
            end
            HTIF_ARB_RESP: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) begin
                    retire     = 1'b1;
                    state_next = HTIF_ARB_IDLE;
                end
            end
            default: state_next = HTIF_ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr         <= 1'b0;
            owner          <= 1'b0;
            timer          <= '0;
            cap_rw         <= 1'b0;
            cap_addr       <= '0;
            cap_data       <= '0;
            resp_data      <= '0;
            resp_err       <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            if (accept) begin
                owner    <= grant_idx;
                cap_rw   <= req_rw[grant_idx];
                cap_addr <= grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                cap_data <= grant_idx ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
            end
            // Timer saturates rather than wrapping.
            if (issue_done) begin
                timer <= '0;
            end else if (state == HTIF_ARB_WAIT && !htif_pcr_resp_valid && timer != '1) begin
                timer <= timer + HTIF_ARB_TIMER_W'(1);
            end
            if (resp_hit) begin
                resp_data <= htif_pcr_resp_data;
                resp_err  <= 1'b0;
            end else if (expire) begin
                resp_data      <= '0;
                resp_err       <= 1'b1;
                timeout_sticky <= 1'b1;
            end
            if (retire) begin
                rr_ptr <= owner;
            end
        end
    end

    assign htif_pcr_req_rw   = cap_rw;
    assign htif_pcr_req_addr = cap_addr;
    assign htif_pcr_req_data = cap_data;

endmodule

// File: tb/tb_vscale_htif_pcr_arbiter.sv
// Directed bench for vscale_htif_pcr_arbiter: single read, contention, both
// backpressure directions, timeout and asynchronous reset mid-transaction.
module tb_vscale_htif_pcr_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;

    logic                clk;
    logic                reset_n;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_rw;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_data;
    logic [1:0]          resp_valid;
    logic [1:0]          resp_ready;
    logic [DATA_W-1:0]   resp_data;
    logic                resp_err;
    logic                htif_pcr_req_valid;
    logic                htif_pcr_req_ready;
    logic                htif_pcr_req_rw;
    logic [ADDR_W-1:0]   htif_pcr_req_addr;
    logic [DATA_W-1:0]   htif_pcr_req_data;
    logic                htif_pcr_resp_valid;
    logic                htif_pcr_resp_ready;
    logic [DATA_W-1:0]   htif_pcr_resp_data;
    logic                timeout_sticky;

    int n_assert = 0;
    int n_fail   = 0;

    vscale_htif_pcr_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_rw              (req_rw),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .resp_valid          (resp_valid),
        .resp_ready          (resp_ready),
        .resp_data           (resp_data),
        .resp_err            (resp_err),
        .htif_pcr_req_valid  (htif_pcr_req_valid),
        .htif_pcr_req_ready  (htif_pcr_req_ready),
        .htif_pcr_req_rw     (htif_pcr_req_rw),
        .htif_pcr_req_addr   (htif_pcr_req_addr),
        .htif_pcr_req_data   (htif_pcr_req_data),
        .htif_pcr_resp_valid (htif_pcr_resp_valid),
        .htif_pcr_resp_ready (htif_pcr_resp_ready),
        .htif_pcr_resp_data  (htif_pcr_resp_data),
        .timeout_sticky      (timeout_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n             = 1'b1;
        req_valid           = 2'b00;
        req_rw              = 2'b00;
        req_addr            = '0;
        req_data            = '0;
        resp_ready          = 2'b00;
        htif_pcr_req_ready  = 1'b0;
        htif_pcr_resp_valid = 1'b0;
        htif_pcr_resp_data  = '0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_htif_req_valid", htif_pcr_req_valid, 1'b0);
        check("rst_htif_resp_ready", htif_pcr_resp_ready, 1'b0);
        check("rst_sticky", timeout_sticky, 1'b0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_htif_addr", htif_pcr_req_addr, 12'h0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Single read, zero-wait on both sides
        req_valid           = 2'b01;
        req_addr[11:0]      = 12'h780;
        htif_pcr_req_ready  = 1'b1;
        htif_pcr_resp_valid = 1'b1;
        htif_pcr_resp_data  = 64'hDEADBEEF;
        resp_ready          = 2'b01;
        #1;
        check("t1_req_ready_c0", req_ready, 2'b01);
        check("t1_resp_valid_c0", resp_valid, 2'b00);
        tick();
        req_valid = 2'b00;
        check("t1_htif_valid_c1", htif_pcr_req_valid, 1'b1);
        check("t1_htif_addr_c1", htif_pcr_req_addr, 12'h780);
        check("t1_htif_rw_c1", htif_pcr_req_rw, 1'b0);
        check("t1_req_ready_c1", req_ready, 2'b00);
        check("t1_resp_valid_c1", resp_valid, 2'b00);
        tick();
        check("t1_htif_resp_ready_c2", htif_pcr_resp_ready, 1'b1);
        check("t1_resp_valid_c2", resp_valid, 2'b00);
        tick();
        check("t1_resp_valid_c3", resp_valid, 2'b01);
        check("t1_resp_data_c3", resp_data, 64'hDEADBEEF);
        check("t1_resp_err_c3", resp_err, 1'b0);
        tick();
        check("t1_resp_valid_c4", resp_valid, 2'b00);

        // Contention: both valid, grants alternate starting at requester 1
        req_addr   = {12'h201, 12'h100};
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic g;
            g = (k % 2 == 0);
            htif_pcr_resp_data = 64'h1000 + 64'(k);
            #1;
            check("t2_grant", req_ready, g ? 2'b10 : 2'b01);
            tick();
            check("t2_htif_addr", htif_pcr_req_addr, g ? 12'h201 : 12'h100);
            tick();
            tick();
            check("t2_resp_owner", resp_valid, g ? 2'b10 : 2'b01);
            check("t2_resp_data", resp_data, 64'h1000 + 64'(k));
            tick();
        end
        req_valid = 2'b00;

        // Downstream backpressure
        htif_pcr_req_ready = 1'b0;
        req_valid          = 2'b01;
        req_rw             = 2'b01;
        req_addr[11:0]     = 12'h345;
        req_data[63:0]     = 64'h1122334455667788;
        resp_ready         = 2'b01;
        #1;
        check("t3_req_ready_idle", req_ready, 2'b01);
        tick();
        req_addr[11:0] = 12'hFFF;
        req_data[63:0] = '0;
        req_valid      = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_htif_valid", htif_pcr_req_valid, 1'b1);
            check("t3_htif_addr", htif_pcr_req_addr, 12'h345);
            check("t3_htif_data", htif_pcr_req_data, 64'h1122334455667788);
            check("t3_htif_rw", htif_pcr_req_rw, 1'b1);
            check("t3_req_ready", req_ready, 2'b00);
            tick();
        end
        check("t3_htif_valid_end", htif_pcr_req_valid, 1'b1);
        htif_pcr_req_ready = 1'b1;
        req_valid          = 2'b00;
        htif_pcr_resp_data = 64'h55;
        tick();
        tick();
        check("t3_resp_valid", resp_valid, 2'b01);
        check("t3_resp_data", resp_data, 64'h55);
        tick();

        // Upstream backpressure on requester 1 while requester 0 waits
        req_valid          = 2'b10;
        req_rw             = 2'b00;
        req_addr[23:12]    = 12'h7C0;
        resp_ready         = 2'b01;
        htif_pcr_resp_data = 64'hCAFE;
        #1;
        check("t4_req_ready_idle", req_ready, 2'b10);
        tick();
        req_valid = 2'b11;
        check("t4_htif_addr", htif_pcr_req_addr, 12'h7C0);
        tick();
        tick();
        for (int i = 0; i < 7; i++) begin
            check("t4_resp_valid_held", resp_valid, 2'b10);
            check("t4_resp_data_held", resp_data, 64'hCAFE);
            check("t4_req_ready_blocked", req_ready, 2'b00);
            htif_pcr_resp_data = 64'hBAD0 + 64'(i);
            tick();
        end
        resp_ready = 2'b10;
        #1;
        check("t4_resp_valid_last", resp_valid, 2'b10);
        tick();
        check("t4_req0_granted", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        check("t4_htif_addr_req0", htif_pcr_req_addr, 12'hFFF);
        tick();
        tick();
        check("t4_resp_valid_req0", resp_valid, 2'b01);
        check("t4_resp_data_req0", resp_data, 64'hBAD6);
        resp_ready = 2'b11;
        tick();

        // Timeout after 4 WAIT cycles, then a normal transaction
        htif_pcr_resp_valid = 1'b0;
        req_valid           = 2'b01;
        req_addr[11:0]      = 12'h123;
        #1;
        check("t5_req_ready_idle", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t5_wait_resp_ready", htif_pcr_resp_ready, 1'b1);
            check("t5_wait_resp_valid", resp_valid, 2'b00);
            check("t5_wait_sticky", timeout_sticky, 1'b0);
            tick();
        end
        check("t5_to_resp_valid", resp_valid, 2'b01);
        check("t5_to_resp_err", resp_err, 1'b1);
        check("t5_to_resp_data", resp_data, 64'h0);
        check("t5_to_sticky", timeout_sticky, 1'b1);
        tick();
        check("t5_idle_sticky", timeout_sticky, 1'b1);
        htif_pcr_resp_valid = 1'b1;
        htif_pcr_resp_data  = 64'h77;
        req_valid           = 2'b10;
        #1;
        check("t5_norm_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("t5_norm_resp_valid", resp_valid, 2'b10);
        check("t5_norm_resp_err", resp_err, 1'b0);
        check("t5_norm_resp_data", resp_data, 64'h77);
        check("t5_norm_sticky", timeout_sticky, 1'b1);
        tick();

        // Asynchronous reset during WAIT
        htif_pcr_resp_valid = 1'b0;
        req_valid           = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        check("t6_in_wait", htif_pcr_resp_ready, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_resp_ready", htif_pcr_resp_ready, 1'b0);
        check("t6_rst_resp_valid", resp_valid, 2'b00);
        check("t6_rst_req_ready", req_ready, 2'b00);
        check("t6_rst_htif_valid", htif_pcr_req_valid, 1'b0);
        check("t6_rst_sticky", timeout_sticky, 1'b0);
        check("t6_rst_resp_data", resp_data, 64'h0);
        req_valid = 2'b11;
        #1;
        check("t6_rst_req_ready_gated", req_ready, 2'b00);
        tick();
        check("t6_rst_held_req_ready", req_ready, 2'b00);
        #2 reset_n = 1'b1;
        #1;
        check("t6_first_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("t6_htif_valid", htif_pcr_req_valid, 1'b1);
        check("t6_htif_addr", htif_pcr_req_addr, 12'h7C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
